// File: rtl/stall_control_if.sv
// Hazard-unit bundle: pipeline status in,
// stage enables and flushes out.
interface stall_control_if #(
  parameter int WIDTH_DATA_LENGTH = 32
);
  logic [WIDTH_DATA_LENGTH-1:0] Inst;
  logic [1:0] Fw_Detected;
  logic       Br_Detected;
  logic [1:0] Br_result;
  logic       PC_Fetch_EN;
  logic       FE_DE_Reg_EN;
  logic       DE_EX_Reg_EN;
  logic       DE_EX_Reg_RST;
  logic       EX_MEM_Reg_RST;
  logic       Stall_Detected;

  modport master (
    output Inst,
    output Fw_Detected,
    output Br_Detected,
    output Br_result,
    input  PC_Fetch_EN,
    input  FE_DE_Reg_EN,
    input  DE_EX_Reg_EN,
    input  DE_EX_Reg_RST,
    input  EX_MEM_Reg_RST,
    input  Stall_Detected
  );

  modport slave (
    input  Inst,
    input  Fw_Detected,
    input  Br_Detected,
    input  Br_result,
    output PC_Fetch_EN,
    output FE_DE_Reg_EN,
    output DE_EX_Reg_EN,
    output DE_EX_Reg_RST,
    output EX_MEM_Reg_RST,
    output Stall_Detected
  );
endinterface

// File: rtl/stall_control.sv
// Load-use stall and branch flush control.
// One-cycle stall per hazard, then WB forwarding.
module stall_control #(
  parameter int WIDTH_DATA_LENGTH = 32
) (
  input logic      clk,
  input logic      rst,
  stall_control_if.slave bus
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic is_load;
  logic hazard;
  logic flush;
  logic stall_done;
  logic sel_rst;
  logic sel_stall;
  logic sel_flush;
  logic unused_bits;

  assign unused_bits = ^{bus.Inst[WIDTH_DATA_LENGTH-1:7],
                         bus.Br_result[1]};

  assign is_load = (bus.Inst[6:0] == OP_LOAD);
  assign hazard  = is_load
                 && (bus.Fw_Detected == 2'b10)
                 && !stall_done;
  assign flush   = bus.Br_Detected && bus.Br_result[0];

  // One-hot selects so the decoder arms never overlap
  assign sel_rst   = rst;
  assign sel_stall = !rst && hazard;
  assign sel_flush = !rst && !hazard && flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_done <= 1'b0;
    end else begin
      stall_done <= hazard;
    end
  end

  always_comb begin
    bus.PC_Fetch_EN    = 1'b1;
    bus.FE_DE_Reg_EN   = 1'b1;
    bus.DE_EX_Reg_EN   = 1'b1;
    bus.DE_EX_Reg_RST  = 1'b0;
    bus.EX_MEM_Reg_RST = 1'b0;
    bus.Stall_Detected = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        bus.PC_Fetch_EN    = 1'b0;
        bus.FE_DE_Reg_EN   = 1'b0;
        bus.DE_EX_Reg_EN   = 1'b0;
        bus.DE_EX_Reg_RST  = 1'b1;
        bus.EX_MEM_Reg_RST = 1'b1;
      end
      sel_stall: begin
        bus.PC_Fetch_EN    = 1'b0;
        bus.FE_DE_Reg_EN   = 1'b0;
        bus.DE_EX_Reg_EN   = 1'b0;
        bus.EX_MEM_Reg_RST = 1'b1;
        bus.Stall_Detected = 1'b1;
      end
      sel_flush: begin
        bus.DE_EX_Reg_RST  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_stall_control.sv
// Self-checking bench for stall_control:
// directed cases plus randomized model compare.
module tb_stall_control;

  localparam int W = 32;
  localparam logic [5:0] O_RST   = 6'b000110;
  localparam logic [5:0] O_STALL = 6'b000011;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_NORM  = 6'b111000;
  localparam logic [31:0] LW = 32'hf9c3a303;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  bit prev_stalled = 1'b0;

  always #5 clk = ~clk;

  stall_control_if #(.WIDTH_DATA_LENGTH(W)) bus ();

  stall_control #(.WIDTH_DATA_LENGTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [5:0] observed();
    return {bus.PC_Fetch_EN, bus.FE_DE_Reg_EN,
            bus.DE_EX_Reg_EN, bus.DE_EX_Reg_RST,
            bus.EX_MEM_Reg_RST, bus.Stall_Detected};
  endfunction

  function automatic bit stall_now();
    return !rst && (bus.Inst[6:0] == 7'h03)
        && (bus.Fw_Detected == 2'd2) && !prev_stalled;
  endfunction

  function automatic logic [5:0] model();
    if (rst) return O_RST;
    if (stall_now()) return O_STALL;
    if (bus.Br_Detected && bus.Br_result[0])
      return O_FLUSH;
    return O_NORM;
  endfunction

  task automatic drive(input logic [31:0] i,
                       input logic [1:0] f,
                       input logic b,
                       input logic [1:0] r);
    @(negedge clk);
    bus.Inst = i;
    bus.Fw_Detected = f;
    bus.Br_Detected = b;
    bus.Br_result = r;
    #1;
  endtask

  task automatic advance();
    bit nxt;
    nxt = stall_now();
    @(posedge clk);
    prev_stalled = rst ? 1'b0 : nxt;
  endtask

  task automatic test_reset();
    bus.Inst = LW;
    bus.Fw_Detected = 2'b10;
    bus.Br_Detected = 1'b1;
    bus.Br_result = 2'b01;
    rst = 1'b1;
    #2;
    vectors++;
    if (observed() !== O_RST) begin
      miscompares++;
      $display("FAIL reset got=%b want=%b",
               observed(), O_RST);
    end
    advance();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    drive(32'h12345678, 2'b00, 1'b0, 2'b01);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL normal got=%b want=%b",
               observed(), O_NORM);
    end
    advance();
    foreach (bus.Fw_Detected[k]) begin end
    for (int f = 0; f < 4; f++) begin
      if (f == 2) continue;
      drive(LW, 2'(f), 1'b0, 2'b00);
      vectors++;
      if (observed() !== O_NORM) begin
        miscompares++;
        $display("FAIL no_stall_fw%0d got=%b want=%b",
                 f, observed(), O_NORM);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    drive(LW, 2'b10, 1'b0, 2'b00);
    vectors++;
    if (observed() !== O_STALL) begin
      miscompares++;
      $display("FAIL load_use got=%b want=%b",
               observed(), O_STALL);
    end
    advance();
    drive(LW, 2'b10, 1'b0, 2'b00);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL after_stall got=%b want=%b",
               observed(), O_NORM);
    end
    advance();
    drive(32'h00002083, 2'b10, 1'b0, 2'b00);
    vectors++;
    if (observed() !== O_STALL) begin
      miscompares++;
      $display("FAIL stall_again got=%b want=%b",
               observed(), O_STALL);
    end
    advance();
    drive(32'h00000013, 2'b10, 1'b0, 2'b00);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL non_load got=%b want=%b",
               observed(), O_NORM);
    end
    advance();
  endtask

  task automatic test_priority();
    drive(LW, 2'b10, 1'b1, 2'b01);
    vectors++;
    if (observed() !== O_STALL) begin
      miscompares++;
      $display("FAIL stall_over_br got=%b want=%b",
               observed(), O_STALL);
    end
    advance();
    drive(LW, 2'b10, 1'b1, 2'b01);
    vectors++;
    if (observed() !== O_FLUSH) begin
      miscompares++;
      $display("FAIL held_branch got=%b want=%b",
               observed(), O_FLUSH);
    end
    advance();
  endtask

  task automatic test_branch();
    drive(32'h00000000, 2'b01, 1'b1, 2'b11);
    vectors++;
    if (observed() !== O_FLUSH) begin
      miscompares++;
      $display("FAIL br_taken got=%b want=%b",
               observed(), O_FLUSH);
    end
    advance();
    drive(32'h00000000, 2'b01, 1'b1, 2'b00);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL br_not_taken got=%b want=%b",
               observed(), O_NORM);
    end
    advance();
    drive(32'h00000000, 2'b00, 1'b1, 2'b10);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL br_bit1_only got=%b want=%b",
               observed(), O_NORM);
    end
    advance();
  endtask

  task automatic test_reset_mid_stall();
    drive(LW, 2'b10, 1'b0, 2'b00);
    #2;
    rst = 1'b1;
    prev_stalled = 1'b0;
    #1;
    vectors++;
    if (observed() !== O_RST) begin
      miscompares++;
      $display("FAIL rst_in_stall got=%b want=%b",
               observed(), O_RST);
    end
    advance();
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (observed() !== O_STALL) begin
      miscompares++;
      $display("FAIL restall got=%b want=%b",
               observed(), O_STALL);
    end
    advance();
    drive(LW, 2'b10, 1'b0, 2'b00);
    vectors++;
    if (observed() !== O_NORM) begin
      miscompares++;
      $display("FAIL restall_done got=%b want=%b",
               observed(), O_NORM);
    end
    // Pulse reset between edges to clear a set stall_done
    #1;
    rst = 1'b1;
    prev_stalled = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (observed() !== O_STALL) begin
      miscompares++;
      $display("FAIL rst_clears_done got=%b want=%b",
               observed(), O_STALL);
    end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] i;
    for (int n = 0; n < 300; n++) begin
      i = $urandom;
      if ($urandom_range(1, 0) == 1) i[6:0] = 7'h03;
      drive(i, 2'($urandom_range(3, 0)),
            1'($urandom_range(1, 0)),
            2'($urandom_range(3, 0)));
      if ($urandom_range(19, 0) == 0) begin
        rst = 1'b1;
        prev_stalled = 1'b0;
      end else begin
        rst = 1'b0;
      end
      #1;
      vectors++;
      if (observed() !== model()) begin
        miscompares++;
        $display("FAIL random%0d got=%b want=%b",
                 n, observed(), model());
      end
      advance();
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_priority();
    test_branch();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
